// File: rtl/video_overlay_pkg.sv
// Shared constants and the 8x8 hex glyph font for the video hex overlay.
package video_overlay_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int DIGITS  = 8;

    typedef logic [7:0] glyph_row_t;

    // 16 glyphs (0-F) x 8 rows; bit 7 of each row byte is the leftmost pixel.
    localparam glyph_row_t FONT_HEX [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00}, // 0
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00}, // 1
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00}, // 2
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00}, // 3
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00}, // 4
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00}, // 5
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00}, // 6
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00}, // 7
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00}, // 8
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}, // 9
        '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00}, // A
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00}, // B
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00}, // C
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00}, // D
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00}, // E
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}  // F
    };

    function automatic glyph_row_t font_row(input logic [3:0] nib, input logic [2:0] row);
        return FONT_HEX[nib][row];
    endfunction

endpackage

// File: rtl/hex_font_rom.sv
// Registered hex font lookup: one glyph row byte per cycle.
module hex_font_rom
    import video_overlay_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] nibble_i,
    input  logic [2:0] row_i,
    output logic [7:0] row_bits_o
);

    glyph_row_t row_bits_q;

    // Register the row byte so the glyph bit lines up with stage 2.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) row_bits_q <= '0;
        else       row_bits_q <= font_row(nibble_i, row_i);
    end

    assign row_bits_o = row_bits_q;

endmodule

// File: rtl/video_hex_overlay.sv
// Burns a frame-latched 32-bit value as 8 hex glyphs into the video stream,
// with a fixed 2-cycle delay on every output.
module video_hex_overlay
    import video_overlay_pkg::*;
#(
    parameter int          POS_X     = 8,
    parameter int          POS_Y     = 8,
    parameter logic [23:0] FG_COLOR  = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR  = 24'h000000,
    parameter bit          BG_ENABLE = 1'b1
)(
    input  logic        clk_core_12288,
    input  logic        reset,
    input  logic [23:0] in_rgb,
    input  logic        in_de,
    input  logic        in_skip,
    input  logic        in_vs,
    input  logic        in_hs,
    input  logic [31:0] overlay_value,
    input  logic        overlay_enable,
    output logic [23:0] out_rgb,
    output logic        out_de,
    output logic        out_skip,
    output logic        out_vs,
    output logic        out_hs
);

    logic [9:0]  x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic        de_prev_q;
    logic [31:0] shadow_val_q;
    logic        shadow_en_q;

    logic        in_x, in_y, in_box;
    logic [5:0]  dx;
    logic [2:0]  dy;
    logic [3:0]  nibble;
    logic [7:0]  rom_bits;
    logic        glyph_bit;

    logic [23:0] s1_rgb_q;
    logic        s1_de_q, s1_skip_q, s1_vs_q, s1_hs_q, s1_box_q;
    logic [2:0]  s1_col_q;

    logic [23:0] out_rgb_q;
    logic        out_de_q, out_skip_q, out_vs_q, out_hs_q;

    // Visible-area position counters; both saturate rather than wrap.
    always_comb begin
        x_pos_d = x_pos_q;
        if (in_hs)                              x_pos_d = '0;
        else if (in_de && x_pos_q != 10'h3FF)   x_pos_d = x_pos_q + 10'd1;
        y_pos_d = y_pos_q;
        if (in_vs)                              y_pos_d = '0;
        else if (!in_de && de_prev_q && y_pos_q != 10'h3FF)
                                                y_pos_d = y_pos_q + 10'd1;
    end

    // Box membership and glyph addressing for the current pixel.
    assign in_x   = (int'({22'd0, x_pos_q}) >= POS_X) &&
                    (int'({22'd0, x_pos_q}) <  POS_X + GLYPH_W * DIGITS);
    assign in_y   = (int'({22'd0, y_pos_q}) >= POS_Y) &&
                    (int'({22'd0, y_pos_q}) <  POS_Y + GLYPH_H);
    assign in_box = in_de && shadow_en_q && in_x && in_y;
    assign dx     = 6'(x_pos_q - 10'(POS_X));
    assign dy     = 3'(y_pos_q - 10'(POS_Y));
    // Leftmost digit shows the most significant nibble.
    assign nibble = shadow_val_q[{3'd7 - dx[5:3], 2'b00} +: 4];

    hex_font_rom u_rom (
        .clk_i      (clk_core_12288),
        .rst_i      (reset),
        .nibble_i   (nibble),
        .row_i      (dy),
        .row_bits_o (rom_bits)
    );

    // Counters and the shadow copy; the shadow only moves on the frame pulse,
    // and the vs pixel itself still sees the previous shadow.
    always_ff @(posedge clk_core_12288 or posedge reset) begin
        if (reset) begin
            x_pos_q      <= '0;
            y_pos_q      <= '0;
            de_prev_q    <= 1'b0;
            shadow_val_q <= '0;
            shadow_en_q  <= 1'b0;
        end else begin
            x_pos_q   <= x_pos_d;
            y_pos_q   <= y_pos_d;
            de_prev_q <= in_de;
            if (in_vs) begin
                shadow_val_q <= overlay_value;
                shadow_en_q  <= overlay_enable;
            end
        end
    end

    // Stage 1: delay the stream alongside the font ROM read.
    always_ff @(posedge clk_core_12288 or posedge reset) begin
        if (reset) begin
            s1_rgb_q  <= '0;
            s1_de_q   <= 1'b0;
            s1_skip_q <= 1'b0;
            s1_vs_q   <= 1'b0;
            s1_hs_q   <= 1'b0;
            s1_box_q  <= 1'b0;
            s1_col_q  <= '0;
        end else begin
            s1_rgb_q  <= in_rgb;
            s1_de_q   <= in_de;
            s1_skip_q <= in_skip;
            s1_vs_q   <= in_vs;
            s1_hs_q   <= in_hs;
            s1_box_q  <= in_box;
            s1_col_q  <= dx[2:0];
        end
    end

    assign glyph_bit = rom_bits[3'd7 - s1_col_q];

    // Stage 2: pixel mux and output registers.
    always_ff @(posedge clk_core_12288 or posedge reset) begin
        if (reset) begin
            out_rgb_q  <= '0;
            out_de_q   <= 1'b0;
            out_skip_q <= 1'b0;
            out_vs_q   <= 1'b0;
            out_hs_q   <= 1'b0;
        end else begin
            if (s1_box_q && glyph_bit)      out_rgb_q <= FG_COLOR;
            else if (s1_box_q && BG_ENABLE) out_rgb_q <= BG_COLOR;
            else                            out_rgb_q <= s1_rgb_q;
            out_de_q   <= s1_de_q;
            out_skip_q <= s1_skip_q;
            out_vs_q   <= s1_vs_q;
            out_hs_q   <= s1_hs_q;
        end
    end

    assign out_rgb  = out_rgb_q;
    assign out_de   = out_de_q;
    assign out_skip = out_skip_q;
    assign out_vs   = out_vs_q;
    assign out_hs   = out_hs_q;

endmodule

// File: tb/tb_video_hex_overlay.sv
// Bench for video_hex_overlay: cycle scoreboard over a small raster plus
// table of hand-derived pixel values from captured frames.
module tb_video_hex_overlay;

    typedef struct packed {
        logic [23:0] rgb;
        logic        de, skip, vs, hs;
    } out_t;

    typedef struct {
        out_t ea, eb, ec;
        int   slot, vx, vy;
    } sb_t;

    typedef struct {
        int          slot;
        bit          nb;
        int          vy, vx;
        logic [23:0] exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [23:0] in_rgb;
    logic        in_de, in_skip, in_vs, in_hs;
    logic [31:0] ov_val;
    logic        ov_en;

    logic [23:0] a_rgb, b_rgb, c_rgb;
    logic        a_de, a_skip, a_vs, a_hs;
    logic        b_de, b_skip, b_vs, b_hs;
    logic        c_de, c_skip, c_vs, c_hs;

    int checks = 0;
    int failures = 0;

    sb_t  sbq[$];
    vec_t vt[$];
    logic [23:0] cap_a [5][16][80];
    logic [23:0] cap_b [5][16][80];

    // Reference model state
    int          m_x, m_y;
    bit          m_dp, m_se;
    logic [31:0] m_sv;

    logic [7:0] font [16][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
        '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
        '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
        '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
        '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h60, 8'h00}
    };

    video_hex_overlay #(.POS_X(8), .POS_Y(8), .BG_ENABLE(1'b1)) dut_a (
        .clk_core_12288(clk), .reset(reset), .in_rgb(in_rgb), .in_de(in_de),
        .in_skip(in_skip), .in_vs(in_vs), .in_hs(in_hs),
        .overlay_value(ov_val), .overlay_enable(ov_en),
        .out_rgb(a_rgb), .out_de(a_de), .out_skip(a_skip), .out_vs(a_vs), .out_hs(a_hs));

    video_hex_overlay #(.POS_X(8), .POS_Y(8), .BG_ENABLE(1'b0)) dut_b (
        .clk_core_12288(clk), .reset(reset), .in_rgb(in_rgb), .in_de(in_de),
        .in_skip(in_skip), .in_vs(in_vs), .in_hs(in_hs),
        .overlay_value(ov_val), .overlay_enable(ov_en),
        .out_rgb(b_rgb), .out_de(b_de), .out_skip(b_skip), .out_vs(b_vs), .out_hs(b_hs));

    // Box placed right of the 80-pixel active width: must be pure pass-through.
    video_hex_overlay #(.POS_X(100), .POS_Y(8), .BG_ENABLE(1'b1)) dut_c (
        .clk_core_12288(clk), .reset(reset), .in_rgb(in_rgb), .in_de(in_de),
        .in_skip(in_skip), .in_vs(in_vs), .in_hs(in_hs),
        .overlay_value(ov_val), .overlay_enable(ov_en),
        .out_rgb(c_rgb), .out_de(c_de), .out_skip(c_skip), .out_vs(c_vs), .out_hs(c_hs));

    task automatic chk(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic out_t model(input int px, input int py, input bit bg);
        out_t o;
        int dx, dy;
        logic [3:0] nib;
        logic [7:0] rowb;
        o = '{rgb: in_rgb, de: in_de, skip: in_skip, vs: in_vs, hs: in_hs};
        if (reset) return '0;
        dx = m_x - px;
        dy = m_y - py;
        if (in_de && m_se && dx >= 0 && dx < 64 && dy >= 0 && dy < 8) begin
            nib  = 4'((m_sv >> (4 * (7 - dx / 8))) & 32'hF);
            rowb = font[nib][dy];
            if (rowb[7 - (dx % 8)]) o.rgb = 24'hFFFFFF;
            else if (bg)            o.rgb = 24'h000000;
        end
        return o;
    endfunction

    task automatic model_update();
        if (reset) begin
            m_x = 0; m_y = 0; m_dp = 0; m_sv = '0; m_se = 0;
        end else begin
            if (in_vs) begin m_sv = ov_val; m_se = ov_en; end
            if (in_hs) m_x = 0;
            else if (in_de && m_x < 1023) m_x++;
            if (in_vs) m_y = 0;
            else if (!in_de && m_dp && m_y < 1023) m_y++;
            m_dp = in_de;
        end
    endtask

    task automatic check_pop();
        sb_t e;
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL sb_underflow actual=0 required=1");
            return;
        end
        e = sbq.pop_front();
        chk("sb_a", {a_rgb, a_de, a_skip, a_vs, a_hs}, e.ea);
        chk("sb_b", {b_rgb, b_de, b_skip, b_vs, b_hs}, e.eb);
        chk("sb_c", {c_rgb, c_de, c_skip, c_vs, c_hs}, e.ec);
        if (e.slot >= 0) begin
            cap_a[e.slot][e.vy][e.vx] = a_rgb;
            cap_b[e.slot][e.vy][e.vx] = b_rgb;
        end
    endtask

    // One pixel clock: check the output due now, then drive and predict.
    task automatic clk_cycle(input logic r, input logic de, input logic vs, input logic hs,
                             input logic [23:0] rgb, input int slot, input int vx, input int vy);
        sb_t e;
        @(negedge clk);
        check_pop();
        if (r && !reset) begin
            reset = 1'b1;
            // Pixels still in flight are flushed by the reset.
            foreach (sbq[i]) begin
                sbq[i].ea = '0; sbq[i].eb = '0; sbq[i].ec = '0; sbq[i].slot = -1;
            end
            #1;
            chk("rst_async", {a_rgb, a_de, a_skip, a_vs, a_hs}, '0);
        end
        reset   = r;
        in_de   = de;
        in_vs   = vs;
        in_hs   = hs;
        in_rgb  = rgb;
        in_skip = 1'($urandom_range(0, 1));
        e.ea   = model(8, 8, 1'b1);
        e.eb   = model(8, 8, 1'b0);
        e.ec   = model(100, 8, 1'b1);
        e.slot = r ? -1 : slot;
        e.vx   = vx;
        e.vy   = vy;
        sbq.push_back(e);
        model_update();
    endtask

    // Raster: 100 clk/line, 24 lines; DE at tx 10..89 on lines 4..19.
    task automatic run_frame(input int slot, input bit fill, input int rst_line,
                             input int rst_tx, input int chg_line, input logic [31:0] chg_val);
        for (int ln = 0; ln < 24; ln++) begin
            for (int tx = 0; tx < 100; tx++) begin
                logic de, r;
                logic [23:0] rgb;
                de  = (ln >= 4 && ln < 20 && tx >= 10 && tx < 90);
                rgb = fill ? 24'hABCDEF : {8'(tx), 8'(ln), 8'h5A};
                r   = (ln == rst_line && tx >= rst_tx && tx < rst_tx + 5);
                if (ln == chg_line && tx == 0) ov_val = chg_val;
                clk_cycle(r, de, (ln == 0 && tx == 0), (tx == 0), rgb,
                          de ? slot : -1, tx - 10, ln - 4);
            end
        end
    endtask

    initial begin
        sb_t z;
        reset = 1'b1; in_rgb = 24'h123456; in_de = 1'b1; in_skip = 1'b0;
        in_vs = 1'b0; in_hs = 1'b0; ov_val = '0; ov_en = 1'b0;
        m_x = 0; m_y = 0; m_dp = 0; m_sv = '0; m_se = 0;
        z.ea = '0; z.eb = '0; z.ec = '0; z.slot = -1; z.vx = 0; z.vy = 0;
        sbq.push_back(z);
        sbq.push_back(z);

        // {slot, BG_ENABLE=0 instance, visible y, visible x, expected rgb}
        vt.push_back('{0, 0,  8,  8, 24'h000000});
        vt.push_back('{0, 0,  8,  9, 24'h000000});
        vt.push_back('{0, 0,  8, 10, 24'hFFFFFF});
        vt.push_back('{0, 0,  8, 13, 24'hFFFFFF});
        vt.push_back('{0, 0,  8, 14, 24'h000000});
        vt.push_back('{0, 0,  8, 15, 24'h000000});
        vt.push_back('{0, 0,  8, 18, 24'hFFFFFF});
        vt.push_back('{0, 0,  8, 71, 24'h000000});
        vt.push_back('{0, 0,  8, 72, 24'h520C5A});
        vt.push_back('{0, 0,  7, 10, 24'h140B5A});
        vt.push_back('{0, 0,  9,  9, 24'hFFFFFF});
        vt.push_back('{0, 0,  9, 11, 24'h000000});
        vt.push_back('{0, 0, 15, 10, 24'h000000});
        vt.push_back('{1, 0,  8, 10, 24'h000000});
        vt.push_back('{1, 0,  8, 11, 24'hFFFFFF});
        vt.push_back('{1, 0,  8, 18, 24'hFFFFFF});
        vt.push_back('{1, 0,  8, 56, 24'h000000});
        vt.push_back('{1, 0,  8, 57, 24'hFFFFFF});
        vt.push_back('{1, 0, 11, 65, 24'h000000});
        vt.push_back('{1, 0, 11, 66, 24'hFFFFFF});
        vt.push_back('{2, 0,  8,  8, 24'h000000});
        vt.push_back('{2, 0,  8,  9, 24'hFFFFFF});
        vt.push_back('{2, 1,  8,  8, 24'hABCDEF});
        vt.push_back('{2, 1,  8,  9, 24'hFFFFFF});
        vt.push_back('{2, 1,  8, 15, 24'hABCDEF});
        vt.push_back('{2, 1, 14,  9, 24'hFFFFFF});
        vt.push_back('{2, 1, 14, 11, 24'hABCDEF});
        vt.push_back('{2, 0, 14, 11, 24'h000000});
        vt.push_back('{2, 1,  7, 10, 24'hABCDEF});
        vt.push_back('{3, 0,  8,  8, 24'h000000});
        vt.push_back('{3, 0,  8,  9, 24'hFFFFFF});
        vt.push_back('{3, 0, 12,  9, 24'h13105A});
        vt.push_back('{3, 0, 12, 10, 24'h14105A});
        vt.push_back('{4, 0,  8,  8, 24'h000000});
        vt.push_back('{4, 0,  8,  9, 24'hFFFFFF});
        vt.push_back('{4, 0,  8, 16, 24'h000000});
        vt.push_back('{4, 0,  8, 17, 24'hFFFFFF});
        vt.push_back('{4, 0, 14, 65, 24'hFFFFFF});

        // Reset held with live input, then release without any vs.
        repeat (4) clk_cycle(1'b1, 1'b1, 1'b0, 1'b0, 24'h123456, -1, 0, 0);
        repeat (6) clk_cycle(1'b0, 1'b1, 1'b0, 1'b0, 24'h123456, -1, 0, 0);
        repeat (5) clk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, -1, 0, 0);

        ov_val = 32'h0000_0000; ov_en = 1'b1;
        run_frame(0, 1'b0, -1, 0, -1, '0);
        ov_en = 1'b0;
        run_frame(-1, 1'b0, -1, 0, -1, '0);
        ov_val = 32'h1234_5678; ov_en = 1'b1;
        run_frame(1, 1'b0, -1, 0, 6, 32'hFFFF_FFFF);
        run_frame(2, 1'b1, -1, 0, -1, '0);
        ov_val = 32'hDEAD_BEEF;
        run_frame(3, 1'b0, 14, 60, -1, '0);
        run_frame(4, 1'b0, -1, 0, -1, '0);
        repeat (2) clk_cycle(1'b0, 1'b0, 1'b0, 1'b0, 24'h000000, -1, 0, 0);

        foreach (vt[i]) begin
            logic [23:0] act;
            act = vt[i].nb ? cap_b[vt[i].slot][vt[i].vy][vt[i].vx]
                           : cap_a[vt[i].slot][vt[i].vy][vt[i].vx];
            checks++;
            if (act !== vt[i].exp) begin
                failures++;
                $display("FAIL pix slot=%0d nb=%0d y=%0d x=%0d actual=%h required=%h",
                         vt[i].slot, vt[i].nb, vt[i].vy, vt[i].vx, act, vt[i].exp);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_hex_overlay.md
Name: video_hex_overlay

Overview:
- Downstream of the pixel-clock video generator, inline before the scaler outputs.
- Consumes the generator's RGB/DE/SKIP/VS/HS stream and burns a 32-bit debug value into the picture as 8 hex digits (8x8 glyph cells) at a fixed position.
- Everything else passes through unchanged with a fixed 2-cycle delay.
- Single clock domain. overlay_value and overlay_enable must already be synchronized into clk_core_12288 by the producer.

Parameters:
- POS_X, 8: visible-x of the left edge of digit 7 (most significant nibble).
- POS_Y, 8: visible-y of the top glyph row.
- FG_COLOR, 24'hFFFFFF: colour of set glyph pixels.
- BG_COLOR, 24'h000000: colour of clear glyph pixels inside the 64x8 box.
- BG_ENABLE, 1: 1 = paint BG_COLOR inside the box; 0 = clear glyph pixels pass input through.

Ports:
- clk_core_12288  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- in_rgb  in  24  pixel from generator
- in_de  in  1  data enable
- in_skip  in  1  skip flag
- in_vs  in  1  frame-start pulse, 1 cycle
- in_hs  in  1  line-start pulse, 1 cycle
- overlay_value  in  32  value to display
- overlay_enable  in  1  overlay on/off
- out_rgb  out  24  pixel to scaler
- out_de  out  1  delayed in_de
- out_skip  out  1  delayed in_skip
- out_vs  out  1  delayed in_vs
- out_hs  out  1  delayed in_hs

Behaviour:
- Reset (async assert, sync release): all outputs 0; shadow value 0; shadow enable 0; x_pos/y_pos 0; pipeline flushed.
- Latency: exactly 2 cycles for every output. out_de/skip/vs/hs are in_* delayed 2; ordering between signals is preserved.
- Shadow latch:
  - On the cycle in_vs=1, shadow_value <= overlay_value and shadow_en <= overlay_enable.
  - The new values take effect from the next cycle. No mid-frame change is ever visible, so there is no tearing.
- x_pos (10-bit):
  - in_hs -> 0.
  - Otherwise increments on each cycle with in_de=1; saturates at 1023.
- y_pos (10-bit):
  - in_vs -> 0.
  - Otherwise increments on the falling edge of in_de (in_de=0 while the previous in_de=1); saturates at 1023.
- Stage 1, registered:
  - in_box = in_de & shadow_en & (POS_X <= x_pos < POS_X+64) & (POS_Y <= y_pos < POS_Y+8).
  - digit = (x_pos-POS_X)>>3; nibble = shadow_value[4*(7-digit)+:4].
  - row = y_pos-POS_Y; col = (x_pos-POS_X)&7.
  - The font ROM lookup is registered here, so the glyph bit is available at stage 2.
- Stage 2, registered:
  - If in_box and bit=1: out_rgb = FG_COLOR.
  - Else if in_box and BG_ENABLE: out_rgb = BG_COLOR.
  - Else out_rgb = in_rgb delayed 2.
  - Outside DE, out_rgb passes through unmodified (normally 0).
- Clipping: parts of the box outside the DE region are never drawn. Parameters placing the box beyond the active area give pure pass-through.
- Simultaneous in_vs and in_de: the pixel uses the old shadow values.
- Reset mid-frame: outputs drop to 0 immediately. After release, shadow_en=0, so the overlay stays hidden until the first in_vs.
- Bit order: glyph row byte bit 7 is the leftmost pixel (col 0).

Decomposition:
- Package video_overlay_pkg:
  - GLYPH_W=8, GLYPH_H=8, DIGITS=8.
  - FONT_HEX: 16 glyphs x 8 rows x 8 bits. Glyph 0 row 0 = 8'h3C; row 7 = 8'h00 for all glyphs.
- Sub-module hex_font_rom: inputs nibble[3:0] and row[2:0], registered row byte out.

Test Plan:
- Reset/pass-through:
  - Hold reset, drive in_rgb=24'h123456, in_de=1 -> all outputs 0.
  - Release reset with no vs -> out_rgb=24'h123456 and out_de=1 exactly 2 cycles after input.
- Glyph render:
  - Timing 400 clk/line, 512 lines, DE at x=10..329 for lines 10..297; POS_X=POS_Y=8; value 32'h0, enable=1.
  - Frame after vs, line y=8: visible x=10..13 = FFFFFF; x=8,9,14,15 = 000000; x=16 starts digit 6 with the same pattern.
- Disabled: overlay_enable=0 over a full frame -> all outputs bit-exact equal to inputs delayed 2.
- Tear-free:
  - Set value 32'h12345678, pulse vs, then change to 32'hFFFFFFFF mid-frame.
  - Current frame shows "12345678" (digit 7 = glyph 1). Next frame shows all glyph F.
- BG_ENABLE=0: fill input with 24'hABCDEF -> clear box pixels read ABCDEF, set pixels read FFFFFF.
- Mid-line reset: assert reset at x=100 of line 20 -> outputs 0 same cycle; after release, no overlay until the next in_vs, then correct digits.
